turfio_phase_tracker: RTL and testbench

- Parametrised phase tracker for one TURFIO interface clock domain (1x or Nx of sysclk).
- Recovers the position within the 8-sysclk-cycle sequence from the sysclk-domain `sysclk_phase_i` marker.
- Adds what the fixed-ratio trackers in the interface clocking logic lack:
  - alignment checking on every marker, with an error counter,
  - strict or self-realigning mode,
  - a missing-marker watchdog, and a lock indication.
- One instance per interface clock, placed beside the interface MMCMs.

---
 rtl/turfio_phase_pkg.sv | 20 ++
 rtl/turfio_phase_wdog.sv | 31 +++
 rtl/turfio_phase_tracker.sv | 129 ++++++++++++
 tb/tb_turfio_phase_tracker.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/turfio_phase_pkg.sv
// Shared types and helpers for the TURFIO phase tracker.
//   phase_state_t : tracker FSM encoding (IDLE must stay 0 so reset clears locked_o)
//   MODE_*        : accepted values of the tracker MODE parameter
//   cnt_w()       : counter width needed to hold values 0..n-1
package turfio_phase_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    ERR    = 2'd2
  } phase_state_t;

  localparam logic [63:0] MODE_REALIGN = "REALIGN";
  localparam logic [63:0] MODE_STRICT  = "STRICT";

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/turfio_phase_wdog.sv
// Missing-marker timer for the phase tracker.
//   clk_i/rst_i : interface clock, async active-high reset
//   clear_i     : restart the window (marker seen, or tracker not locked)
//   enable_i    : count while the tracker is locked
//   expired_o   : high in the last cycle of a LIMIT-cycle window with no marker
module turfio_phase_wdog #(
  parameter int unsigned LIMIT = 32,
  parameter int unsigned W     = 6
)(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  // Clear loads 1: the cycle after a marker is already one cycle since it, so
  // expiry in the cycle holding LIMIT-1 drops lock exactly LIMIT edges later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                       r_cnt <= '0;
    else if (clear_i)                r_cnt <= W'(1);
    else if (enable_i && !expired_o) r_cnt <= r_cnt + W'(1);
  end

  assign expired_o = enable_i && (r_cnt == LAST);

endmodule

// File: rtl/turfio_phase_tracker.sv
// Recovers the position within the SEQ_LEN-sysclk sequence in an interface
// clock domain running at MULT x sysclk, from the sysclk-domain marker.
// Checks alignment on every marker, counts mismatches, and drops lock when
// markers stop.
//   ifclk_i/rst_i   : interface clock, async active-high reset
//   sysclk_phase_i  : sequence marker (one sysclk cycle wide)
//   realign_i       : force IDLE; a same-cycle marker edge is ignored
//   err_clr_i       : clear the mismatch counter
//   phase_count_o   : position 0..P-1, P = SEQ_LEN*MULT
//   phase_o         : high while phase_count_o == 0
//   locked_o        : high in LOCKED
//   err_o           : one-cycle pulse per mismatch
//   err_count_o     : saturating mismatch count
module turfio_phase_tracker
  import turfio_phase_pkg::*;
#(
  parameter int unsigned MULT         = 1,
  parameter int unsigned SEQ_LEN      = 8,
  parameter int unsigned ALIGN_VAL    = 2,
  parameter logic [63:0] MODE         = MODE_REALIGN,
  parameter int unsigned WDOG_PERIODS = 2,
  parameter int unsigned ERRW         = 8,
  localparam int unsigned P  = SEQ_LEN * MULT,
  localparam int unsigned PW = cnt_w(P)
)(
  input  logic            ifclk_i,
  input  logic            rst_i,
  input  logic            sysclk_phase_i,
  input  logic            realign_i,
  input  logic            err_clr_i,
  output logic [PW-1:0]   phase_count_o,
  output logic            phase_o,
  output logic            locked_o,
  output logic            err_o,
  output logic [ERRW-1:0] err_count_o
);

  localparam int unsigned WD_LIMIT = WDOG_PERIODS * P;
  localparam int unsigned WD_W     = cnt_w(WD_LIMIT + 1);
  localparam logic [PW-1:0] LAST   = PW'(P - 1);
  localparam logic [PW-1:0] ALIGN  = PW'(ALIGN_VAL);
  localparam bit STRICT            = (MODE == MODE_STRICT);

  if (P < 4) begin : g_bad_p
    $error("turfio_phase_tracker: SEQ_LEN*MULT must be >= 4");
  end
  if (ALIGN_VAL >= P) begin : g_bad_align
    $error("turfio_phase_tracker: ALIGN_VAL must be < SEQ_LEN*MULT");
  end
  if (MODE != MODE_REALIGN && MODE != MODE_STRICT) begin : g_bad_mode
    $error("turfio_phase_tracker: MODE must be REALIGN or STRICT");
  end

  phase_state_t  r_state, w_state_nxt;
  logic          r_s1, r_s2;
  logic [PW-1:0] r_cnt, w_cnt_inc, w_cnt_nxt;
  logic          r_phase, r_err;
  logic [ERRW-1:0] r_err_cnt;
  logic          w_edge, w_edge_v, w_mismatch, w_load, w_wdog_exp;

  // Marker is held for MULT fast cycles; rising-edge detect gives one hit.
  always_ff @(posedge ifclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= sysclk_phase_i;
      r_s2 <= r_s1;
    end
  end

  assign w_edge     = r_s1 & ~r_s2;
  assign w_edge_v   = w_edge & ~realign_i;
  assign w_cnt_inc  = (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
  assign w_mismatch = (r_state == LOCKED) && w_edge_v && (w_cnt_inc != ALIGN);
  assign w_load     = w_edge_v && ((r_state == IDLE) || (w_mismatch && !STRICT));
  assign w_cnt_nxt  = w_load ? ALIGN : w_cnt_inc;

  always_comb begin
    w_state_nxt = r_state;
    if (realign_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_edge) w_state_nxt = LOCKED;
        LOCKED:  if (w_mismatch && STRICT)    w_state_nxt = ERR;
                 else if (!w_edge && w_wdog_exp) w_state_nxt = IDLE;
        ERR:     w_state_nxt = ERR;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge ifclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_phase   <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= (w_cnt_nxt == '0);
      r_err   <= w_mismatch;
      // A clear that collides with a mismatch keeps that mismatch.
      if (err_clr_i)                          r_err_cnt <= w_mismatch ? ERRW'(1) : '0;
      else if (w_mismatch && r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERRW'(1);
    end
  end

  turfio_phase_wdog #(
    .LIMIT (WD_LIMIT),
    .W     (WD_W)
  ) u_wdog (
    .clk_i     (ifclk_i),
    .rst_i     (rst_i),
    .clear_i   (w_edge | realign_i | (r_state != LOCKED)),
    .enable_i  (r_state == LOCKED),
    .expired_o (w_wdog_exp)
  );

  assign phase_count_o = r_cnt;
  assign phase_o       = r_phase;
  assign locked_o      = (r_state == LOCKED);
  assign err_o         = r_err;
  assign err_count_o   = r_err_cnt;

endmodule

// File: tb/tb_turfio_phase_tracker.sv
// Directed bench: three trackers (MULT=2, SEQ_LEN=8, ALIGN_VAL=2) share one
// stimulus stream -- A: REALIGN/ERRW=8, B: STRICT/ERRW=8, C: REALIGN/ERRW=2.
module tb_turfio_phase_tracker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mk = 1'b0, realign = 1'b0, eclr = 1'b0;

  logic [3:0] a_cnt, b_cnt, c_cnt;
  logic       a_ph, b_ph, c_ph, a_lk, b_lk, c_lk, a_er, b_er, c_er;
  logic [7:0] a_ec, b_ec;
  logic [1:0] c_ec;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  turfio_phase_tracker #(.MULT(2), .SEQ_LEN(8), .ALIGN_VAL(2), .MODE("REALIGN"),
    .WDOG_PERIODS(2), .ERRW(8)) u_a (
    .ifclk_i(clk), .rst_i(rst), .sysclk_phase_i(mk), .realign_i(realign),
    .err_clr_i(eclr), .phase_count_o(a_cnt), .phase_o(a_ph), .locked_o(a_lk),
    .err_o(a_er), .err_count_o(a_ec));

  turfio_phase_tracker #(.MULT(2), .SEQ_LEN(8), .ALIGN_VAL(2), .MODE("STRICT"),
    .WDOG_PERIODS(2), .ERRW(8)) u_b (
    .ifclk_i(clk), .rst_i(rst), .sysclk_phase_i(mk), .realign_i(realign),
    .err_clr_i(eclr), .phase_count_o(b_cnt), .phase_o(b_ph), .locked_o(b_lk),
    .err_o(b_er), .err_count_o(b_ec));

  turfio_phase_tracker #(.MULT(2), .SEQ_LEN(8), .ALIGN_VAL(2), .MODE("REALIGN"),
    .WDOG_PERIODS(2), .ERRW(2)) u_c (
    .ifclk_i(clk), .rst_i(rst), .sysclk_phase_i(mk), .realign_i(realign),
    .err_clr_i(eclr), .phase_count_o(c_cnt), .phase_o(c_ph), .locked_o(c_lk),
    .err_o(c_er), .err_count_o(c_ec));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Two-cycle marker; returns just after the edge that loads the counter.
  // clr raises err_clr_i in the cycle the edge is being evaluated.
  task automatic mark(input bit clr);
    mk = 1'b1;
    tick();
    eclr = clr;
    tick();
    eclr = 1'b0;
    mk = 1'b0;
  endtask

  initial begin
    // ---- reset ----
    #2 rst = 1'b1;
    #1;
    chk("rst_cnt", a_cnt, 0);
    chk("rst_phase", a_ph, 0);
    chk("rst_lock", a_lk, 0);
    chk("rst_err", a_er, 0);
    chk("rst_ecnt", a_ec, 0);
    run(2);
    rst = 1'b0;
    run(3);

    // ---- 1: lock and steady state ----
    mk = 1'b1;
    tick();
    chk("t1_lock_early", a_lk, 0);
    tick();
    mk = 1'b0;
    chk("t1_lock_a", a_lk, 1);
    chk("t1_lock_b", b_lk, 1);
    chk("t1_load", a_cnt, 2);
    for (int p = 0; p < 3; p++) begin
      run(13);
      chk("t1_cnt15", a_cnt, 15);
      chk("t1_ph_lo", a_ph, 0);
      run(1);
      chk("t1_cnt0", a_cnt, 0);
      chk("t1_ph_hi", a_ph, 1);
      mark(1'b0);
      chk("t1_cnt2", a_cnt, 2);
      chk("t1_ecnt", a_ec, 0);
    end

    // ---- 2/3: marker shifted by +3 ----
    run(17);
    mark(1'b0);
    chk("t2_err_pulse", a_er, 1);
    chk("t2_ecnt", a_ec, 1);
    chk("t2_reload", a_cnt, 2);
    chk("t2_lock", a_lk, 1);
    chk("t3_ecnt", b_ec, 1);
    chk("t3_unlock", b_lk, 0);
    chk("t3_noload", b_cnt, 5);
    tick();
    chk("t2_err_drop", a_er, 0);
    run(13);
    mark(1'b0);
    chk("t2_realigned", a_er, 0);
    chk("t3_err_stays", b_lk, 0);
    chk("t3_ecnt_hold", b_ec, 1);
    run(3);
    realign = 1'b1;
    tick();
    realign = 1'b0;
    chk("t3_realign_a", a_lk, 0);
    chk("t3_realign_b", b_lk, 0);
    run(10);
    mark(1'b0);
    chk("t3_relock", b_lk, 1);
    chk("t3_relock_cnt", b_cnt, 2);
    chk("t3_relock_a", a_lk, 1);
    chk("t3_relock_ecnt", a_ec, 1);

    // ---- 4: watchdog ----
    run(30);
    chk("t4_still_lock", a_lk, 1);
    run(1);
    chk("t4_unlock", a_lk, 0);
    chk("t4_no_err", a_ec, 1);
    run(5);
    mark(1'b0);
    chk("t4_relock", a_lk, 1);
    chk("t4_relock_ecnt", a_ec, 1);

    // ---- 5: realign on a (misaligned) marker edge ----
    run(16);
    mk = 1'b1;
    tick();
    realign = 1'b1;
    tick();
    realign = 1'b0;
    mk = 1'b0;
    chk("t5_idle", a_lk, 0);
    chk("t5_noload", a_cnt, 4);
    chk("t5_noerr", a_er, 0);
    chk("t5_ecnt", a_ec, 1);
    run(14);
    mark(1'b0);
    chk("t5_lock", a_lk, 1);
    chk("t5_cnt", a_cnt, 2);

    // ---- 6: saturation, clear, async reset ----
    for (int i = 0; i < 4; i++) begin
      run(17);
      mark(1'b0);
      chk("t6_ecnt_a", a_ec, 2 + i);
      chk("t6_ecnt_c", c_ec, (i + 2 > 3) ? 3 : i + 2);
    end
    eclr = 1'b1;
    tick();
    eclr = 1'b0;
    chk("t6_clr_a", a_ec, 0);
    chk("t6_clr_c", c_ec, 0);
    run(1);
    eclr = 1'b1;
    tick();
    eclr = 1'b0;
    run(15);
    mark(1'b1);
    chk("t6_clr_mis_a", a_ec, 1);
    chk("t6_clr_mis_c", c_ec, 1);
    chk("t6_clr_mis_err", a_er, 1);
    run(5);
    #2 rst = 1'b1;
    #1;
    chk("t6_arst_cnt", a_cnt, 0);
    chk("t6_arst_lock", a_lk, 0);
    chk("t6_arst_ecnt", c_ec, 0);
    chk("t6_arst_ecnt_a", a_ec, 0);
    chk("t6_arst_ph", a_ph, 0);
    tick();
    rst = 1'b0;
    run(2);
    mark(1'b0);
    chk("t6_post_lock", a_lk, 1);
    chk("t6_post_cnt", a_cnt, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
